// File: rtl/bcd_counter_multi.sv
// bcd_counter_multi: multi-digit BCD up/down counter with a clock-enable prescaler,
// parallel load with per-digit clamping, and one-cycle tick/wrap pulses.
`default_nettype none

module bcd_counter_multi #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic                  wrap
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]    div;
  logic [4*DIGITS-1:0] q_next;
  logic [4*DIGITS-1:0] load_clamped;
  logic                carry;
  logic                step;

  assign step = en && (div == DIV_LAST);

  // Ripple carry/borrow across digits; a carry out of the top digit is a wrap.
  always_comb begin
    q_next = q;
    carry  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up_dn) begin
          carry = (q[4*i +: 4] == 4'd9);
          q_next[4*i +: 4] = carry ? 4'd0 : q[4*i +: 4] + 4'd1;
        end else begin
          carry = (q[4*i +: 4] == 4'd0);
          q_next[4*i +: 4] = carry ? 4'd9 : q[4*i +: 4] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      q    <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      div  <= '0;
      q    <= load_clamped;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (en) begin
      tick <= step;
      wrap <= step && carry;
      if (step) begin
        div <= '0;
        q   <= q_next;
      end else begin
        div <= div + DIV_W'(1);
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_multi.sv
// Directed testbench for bcd_counter_multi: a TICK_DIV=4 instance and a TICK_DIV=1 instance.
`default_nettype none

module tb_bcd_counter_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset = 1'b1, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
  logic [7:0] a_lv = 8'h00;
  logic [7:0] a_q;
  logic       a_tick, a_wrap;

  logic       b_reset = 1'b1, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
  logic [7:0] b_lv = 8'h00;
  logic [7:0] b_q;
  logic       b_tick, b_wrap;

  bcd_counter_multi #(.DIGITS(2), .TICK_DIV(4), .DIV_W(3)) dut_a (
    .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .load(a_load),
    .load_val(a_lv), .q(a_q), .tick(a_tick), .wrap(a_wrap)
  );

  bcd_counter_multi #(.DIGITS(2), .TICK_DIV(1), .DIV_W(1)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .load(b_load),
    .load_val(b_lv), .q(b_q), .tick(b_tick), .wrap(b_wrap)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int k);
    return 8'(((k / 10) % 10) * 16 + (k % 10));
  endfunction

  initial begin
    // 1: free-running up count, tick every 4th enabled cycle
    cyc(); cyc();
    check("rst_a_q", a_q, 8'h00);
    check("rst_a_tick", a_tick, 0);
    check("rst_a_wrap", a_wrap, 0);
    a_reset = 1'b0; a_en = 1'b1; a_up = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      check("t1_tick", a_tick, (n % 4 == 0) ? 1 : 0);
      check("t1_q", a_q, bcd(n / 4));
      check("t1_wrap", a_wrap, 0);
    end

    // 4: en gaps hold the prescaler
    a_reset = 1'b1; cyc(); a_reset = 1'b0;
    check("t4_rst_q", a_q, 8'h00);
    a_en = 1'b1;
    for (int n = 0; n < 2; n++) begin cyc(); check("t4_tick_on1", a_tick, 0); end
    a_en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cyc(); check("t4_tick_off", a_tick, 0); check("t4_q_off", a_q, 8'h00);
    end
    a_en = 1'b1;
    cyc(); check("t4_tick_3rd", a_tick, 0);
    cyc(); check("t4_tick_4th", a_tick, 1); check("t4_q", a_q, 8'h01);

    // 5: load on the would-be step edge, clamp and restart prescaler
    for (int n = 0; n < 3; n++) begin cyc(); check("t5_pre_tick", a_tick, 0); end
    a_load = 1'b1; a_lv = 8'h5F;
    cyc(); check("t5_load_q", a_q, 8'h59); check("t5_load_tick", a_tick, 0);
    a_load = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc(); check("t5_wait_tick", a_tick, 0); check("t5_wait_q", a_q, 8'h59);
    end
    cyc(); check("t5_tick", a_tick, 1); check("t5_q", a_q, 8'h60);

    // 6: reset beats load and step
    a_en = 1'b0; a_load = 1'b1; a_lv = 8'h37;
    cyc(); a_load = 1'b0;
    check("t6_load_q", a_q, 8'h37);
    a_en = 1'b1;
    for (int n = 0; n < 3; n++) begin cyc(); check("t6_pre_tick", a_tick, 0); end
    a_reset = 1'b1; a_load = 1'b1; a_lv = 8'h12;
    cyc();
    check("t6_rst_q", a_q, 8'h00); check("t6_rst_tick", a_tick, 0); check("t6_rst_wrap", a_wrap, 0);
    a_reset = 1'b0; a_load = 1'b0;
    for (int n = 0; n < 3; n++) begin cyc(); check("t6_post_tick", a_tick, 0); end
    cyc(); check("t6_tick", a_tick, 1); check("t6_q", a_q, 8'h01);

    // 2: TICK_DIV=1 up wrap
    b_reset = 1'b0; b_load = 1'b1; b_lv = 8'h98;
    check("rst_b_q", b_q, 8'h00);
    cyc(); check("t2_load_q", b_q, 8'h98); check("t2_load_tick", b_tick, 0);
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    cyc(); check("t2_q99", b_q, 8'h99); check("t2_tick1", b_tick, 1); check("t2_wrap1", b_wrap, 0);
    cyc(); check("t2_q00", b_q, 8'h00); check("t2_tick2", b_tick, 1); check("t2_wrap2", b_wrap, 1);
    cyc(); check("t2_q01", b_q, 8'h01); check("t2_wrap3", b_wrap, 0);

    // 3: TICK_DIV=1 down wrap and borrow
    b_en = 1'b0; b_load = 1'b1; b_lv = 8'h01;
    cyc(); b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
    check("t3_load_q", b_q, 8'h01);
    cyc(); check("t3_q00", b_q, 8'h00); check("t3_wrap0", b_wrap, 0);
    cyc(); check("t3_q99", b_q, 8'h99); check("t3_wrap1", b_wrap, 1); check("t3_tick", b_tick, 1);
    for (int k = 98; k >= 90; k--) begin
      cyc(); check("t3_qdn", b_q, bcd(k)); check("t3_wrapdn", b_wrap, 0);
    end
    cyc(); check("t3_q89", b_q, 8'h89);

    // both digits out of range clamp to 9
    b_load = 1'b1; b_lv = 8'hAF;
    cyc(); check("clamp_q", b_q, 8'h99); check("clamp_tick", b_tick, 0);
    b_load = 1'b0; b_en = 1'b0;
    cyc(); check("en0_tick", b_tick, 0); check("en0_q", b_q, 8'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
